chirp_pulse_scheduler: RTL
==========================

Name: chirp_pulse_scheduler

Overview:
- Sequences one radar pulse train across two blocks: the waveform_stream buffer and the CHIRP_DDS chirp generator.
- For each pulse it loads the waveform parameters, handshakes init_wf_write/wf_write_ready, fires chirp_init, waits for chirp_done, then enforces the pulse repetition interval (PRI) before the next pulse.
- Sits between the host/control register file and the waveform/chirp datapath, in the 245.76 MHz fmc_tclk domain.

Parameters:
- PRI_W, 32: width of the PRI counter and of pri_cycles.
- NP_W, 16: width of num_pulses and pulse_count.
- TIMEOUT_CYCLES, 4096: maximum wait in any handshake state before the error path.

Ports:
- clk_in1  in  1  fmc_tclk; every flop is on the rising edge.
- reset  in  1  asynchronous, active-high; drives all state to its reset values.
- start  in  1  single-cycle pulse that begins a pulse train.
- abort  in  1  level; terminates the train.
- num_pulses  in  NP_W  pulses per train; 0 means continuous until abort.
- pri_cycles  in  PRI_W  clocks from one chirp_init to the next; minimum 2.
- wf_params_in  in  128  waveform parameter word.
- waveform_parameters  out  128  parameter word latched at start.
- init_wf_write  out  1  waveform write request.
- wf_write_ready  in  1  write-request acknowledge.
- chirp_ready  in  1  DDS idle/ready.
- chirp_init  out  1  one-cycle chirp trigger.
- chirp_done  in  1  one-cycle end-of-chirp.
- busy  out  1  high whenever state is not IDLE.
- pulse_count  out  NP_W  chirps fired in the current train.
- train_done  out  1  one-cycle pulse when the train completes normally.
- overrun  out  1  sticky: a chirp outlasted the PRI.
- timeout_err  out  1  sticky: a handshake exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset values: all outputs 0, waveform_parameters 0, state IDLE.
- States: IDLE, ARM, FIRE, ACTIVE, GAP.
- IDLE:
  - On start, latch num_pulses, pri_cycles and wf_params_in (waveform_parameters is updated in the same edge).
  - Clear pulse_count, overrun and timeout_err; go to ARM.
  - start is ignored in every state other than IDLE.
- ARM:
  - init_wf_write is 1.
  - On the cycle wf_write_ready is sampled 1: init_wf_write drops next edge; go to FIRE.
- FIRE:
  - Waits for chirp_ready=1, then asserts chirp_init for exactly one cycle.
  - In the same edge: increment pulse_count, load the PRI counter with 1, go to ACTIVE.
- ACTIVE:
  - The PRI counter increments every cycle.
  - On chirp_done: if the counter is ≥ pri_cycles, set overrun and go straight to the next pulse decision; otherwise go to GAP.
  - chirp_done sampled in any state other than ACTIVE is ignored.
- GAP:
  - The PRI counter keeps incrementing; when it reaches pri_cycles-1, take the next-pulse decision.
  - Result: chirp_init edges are spaced exactly pri_cycles clocks apart when there is no overrun.
- Next-pulse decision:
  - If num_pulses≠0 and pulse_count==num_pulses: assert train_done for 1 cycle and go to IDLE.
  - Otherwise go to ARM. The waveform write is re-armed every pulse.
- Timeouts:
  - A wait counter runs in ARM, FIRE and ACTIVE and is cleared on every state change.
  - If it reaches TIMEOUT_CYCLES: set timeout_err, drop init_wf_write, go to IDLE, no train_done.
- Abort:
  - abort=1 in any non-IDLE state goes to IDLE at the next edge.
  - init_wf_write and chirp_init are 0 from that edge; pulse_count holds; no train_done.
  - abort has priority over all other transitions.
- Arithmetic:
  - pulse_count wraps modulo 2^NP_W in continuous mode.
  - The PRI counter saturates at all-ones.
  - pri_cycles<2 is treated as 2.
- Reset mid-train: asynchronous return to IDLE with all outputs 0 immediately.

Optional Feature:
- Macro: CHIRP_SCHED_EXT_TRIG_EN.
- When defined:
  - Adds input ext_trig (1 bit, synchronous to clk_in1).
  - GAP exit additionally requires an ext_trig rising edge seen at or after the PRI count is met; pri_cycles becomes a minimum spacing.
  - The wait in GAP is subject to the timeout.
- When undefined: no port is added, and PRI timing is purely internal.

Decomposition:
- Package chirp_sched_pkg holds:
  - the state encoding enum;
  - PRI_MIN=2;
  - widths WF_PARAM_W=128, PRI_W and NP_W defaults.
- One natural sub-module, chirp_sched_timer:
  - contains the PRI counter and the wait/timeout counter;
  - inputs: load, run, limit;
  - outputs: pri_met, timeout_hit.

Test Plan:
1. start with num_pulses=3, pri_cycles=1024, chirp_done 600 clocks after each chirp_init, wf_write_ready 2 clocks after request:
   - exactly 3 chirp_init pulses, 1024 clocks apart;
   - pulse_count=3; train_done once; overrun=0.
2. pri_cycles=500 with chirp_done at 700 clocks:
   - overrun=1;
   - the next ARM starts the cycle after chirp_done;
   - the train still completes.
3. wf_write_ready tied 0:
   - timeout_err=1 after 4096 clocks in ARM;
   - busy=0; no chirp_init; no train_done.
4. num_pulses=0, then abort after the 5th chirp_init:
   - IDLE next edge; pulse_count=5; init_wf_write=0; no train_done.
5. Assert reset during ACTIVE:
   - all outputs 0 immediately;
   - a subsequent start runs a clean train with pulse_count restarting at 1.
6. start pulsed while busy:
   - ignored;
   - the latched waveform_parameters are unchanged when wf_params_in changes mid-train.

Source files
------------

// File: rtl/chirp_sched_pkg.sv
// Purpose: shared widths, limits and state encoding for the chirp pulse scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package chirp_sched_pkg;

  localparam int WF_PARAM_W = 128;
  localparam int PRI_W_DEF  = 32;
  localparam int NP_W_DEF   = 16;

  // Shortest legal PRI; smaller programmed values are raised to this.
  localparam int PRI_MIN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_FIRE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_GAP    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/chirp_sched_timer.sv
// Purpose: PRI interval counter and per-state handshake watchdog for the scheduler.
// Latency: counters update one clock after load/run; flags are combinational from the counters.
// Backpressure: none; the caller decides when the counters run or clear.
module chirp_sched_timer #(
  parameter int PRI_W          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [PRI_W-1:0] limit,
  input  logic             wait_clr,
  input  logic             wait_run,
  output logic             pri_met,
  output logic             pri_over,
  output logic             timeout_hit
);

  localparam int WT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(TIMEOUT_CYCLES - 1);

  logic [PRI_W-1:0] pri_cnt;
  logic [WT_W-1:0]  wait_cnt;

  // PRI counter: restarts at 1 on each chirp trigger, then counts up and sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_cnt <= '0;
    end else if (load) begin
      pri_cnt <= PRI_W'(1);
    end else if (run && (pri_cnt != '1)) begin
      pri_cnt <= pri_cnt + PRI_W'(1);
    end
  end

  // Watchdog: counts cycles spent in one waiting state, cleared whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (wait_clr) begin
      wait_cnt <= '0;
    end else if (wait_run && (wait_cnt != WT_LAST)) begin
      wait_cnt <= wait_cnt + WT_W'(1);
    end
  end

  // The caller keeps limit >= 2, so limit-2 cannot underflow. pri_met is true on the
  // cycle whose closing edge brings the counter to limit-1.
  assign pri_met     = (pri_cnt >= (limit - PRI_W'(2)));
  assign pri_over    = (pri_cnt >= limit);
  assign timeout_hit = wait_run && (wait_cnt == WT_LAST);

endmodule

// File: rtl/chirp_pulse_scheduler.sv
// Purpose: sequences a radar pulse train: waveform write handshake, chirp trigger, PRI spacing.
// Latency: chirp_init rises 3 clocks after start when wf_write_ready and chirp_ready answer at once.
// Backpressure: stalls in ARM/FIRE on wf_write_ready/chirp_ready; watchdog aborts after TIMEOUT_CYCLES.
// Optional: CHIRP_SCHED_EXT_TRIG_EN adds ext_trig; GAP then also waits for its rising edge.
module chirp_pulse_scheduler
  import chirp_sched_pkg::*;
#(
  parameter int PRI_W          = PRI_W_DEF,
  parameter int NP_W           = NP_W_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_in1,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NP_W-1:0]       num_pulses,
  input  logic [PRI_W-1:0]      pri_cycles,
  input  logic [WF_PARAM_W-1:0] wf_params_in,
  output logic [WF_PARAM_W-1:0] waveform_parameters,
  output logic                  init_wf_write,
  input  logic                  wf_write_ready,
  input  logic                  chirp_ready,
  output logic                  chirp_init,
  input  logic                  chirp_done,
`ifdef CHIRP_SCHED_EXT_TRIG_EN
  input  logic                  ext_trig,
`endif
  output logic                  busy,
  output logic [NP_W-1:0]       pulse_count,
  output logic                  train_done,
  output logic                  overrun,
  output logic                  timeout_err
);

  sched_state_t     state;
  sched_state_t     state_nxt;

  logic [NP_W-1:0]  np_lat;
  logic [PRI_W-1:0] pri_lat;

  logic accept;
  logic fire;
  logic decide;
  logic finish;
  logic fail;
  logic set_ovr;
  logic last_pulse;
  logic wait_run;

  logic pri_met;
  logic pri_over;
  logic timeout_hit;

`ifdef CHIRP_SCHED_EXT_TRIG_EN
  logic ext_trig_q;
  logic trig_rise;

  // Delayed copy of ext_trig for rising-edge detection.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      ext_trig_q <= 1'b0;
    end else begin
      ext_trig_q <= ext_trig;
    end
  end

  assign trig_rise = ext_trig & ~ext_trig_q;
  // The external trigger may hold the gap indefinitely, so the watchdog covers it too.
  assign wait_run  = (state == ST_ARM) || (state == ST_FIRE) ||
                     (state == ST_ACTIVE) || (state == ST_GAP);
`else
  assign wait_run  = (state == ST_ARM) || (state == ST_FIRE) || (state == ST_ACTIVE);
`endif

  // Train ends once the programmed count is reached; zero means run until aborted.
  assign last_pulse = (np_lat != '0) && (pulse_count == np_lat);

  chirp_sched_timer #(
    .PRI_W          (PRI_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk         (clk_in1),
    .rst         (reset),
    .load        (fire),
    .run         (busy),
    .limit       (pri_lat),
    .wait_clr    (state_nxt != state),
    .wait_run    (wait_run),
    .pri_met     (pri_met),
    .pri_over    (pri_over),
    .timeout_hit (timeout_hit)
  );

  // State register.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle events; abort overrides everything else.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fire      = 1'b0;
    decide    = 1'b0;
    finish    = 1'b0;
    fail      = 1'b0;
    set_ovr   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (wf_write_ready) begin
          state_nxt = ST_FIRE;
        end else if (timeout_hit) begin
          fail      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_FIRE: begin
        if (chirp_ready) begin
          fire      = 1'b1;
          state_nxt = ST_ACTIVE;
        end else if (timeout_hit) begin
          fail      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (chirp_done) begin
          if (pri_over) begin
            // Chirp already used up the whole interval: skip the gap.
            set_ovr = 1'b1;
            decide  = 1'b1;
          end else begin
            state_nxt = ST_GAP;
          end
        end else if (timeout_hit) begin
          fail      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
`ifdef CHIRP_SCHED_EXT_TRIG_EN
        if (pri_met && trig_rise) begin
          decide = 1'b1;
        end else if (timeout_hit) begin
          fail      = 1'b1;
          state_nxt = ST_IDLE;
        end
`else
        if (pri_met) begin
          decide = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (decide) begin
      if (last_pulse) begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = ST_ARM;
      end
    end

    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      fire      = 1'b0;
      finish    = 1'b0;
      fail      = 1'b0;
      set_ovr   = 1'b0;
    end
  end

  // Train configuration captured at start; the host may change its inputs mid-train.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      np_lat              <= '0;
      pri_lat             <= PRI_W'(PRI_MIN);
      waveform_parameters <= '0;
    end else if (accept) begin
      np_lat              <= num_pulses;
      pri_lat             <= (pri_cycles < PRI_W'(PRI_MIN)) ? PRI_W'(PRI_MIN) : pri_cycles;
      waveform_parameters <= wf_params_in;
    end
  end

  // Pulse counting, one-cycle strobes and sticky error flags.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      pulse_count <= '0;
      chirp_init  <= 1'b0;
      train_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      chirp_init <= fire;
      train_done <= finish;
      if (accept) begin
        pulse_count <= '0;
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (fire) begin
          pulse_count <= pulse_count + NP_W'(1);
        end
        if (set_ovr) begin
          overrun <= 1'b1;
        end
        if (fail) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

  // Write request is simply "in ARM", so abort, timeout and reset drop it on the same edge.
  assign init_wf_write = (state == ST_ARM);
  assign busy          = (state != ST_IDLE);

endmodule
